// File: rtl/sft_pkg.sv
// sft_pkg: shared types and OPCODE field positions for the operand-2 shifter.
// Optional build macro: SFT_REGSHIFT_2CYC_EN (adds the EXTRA state).
package sft_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

`ifdef SFT_REGSHIFT_2CYC_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FULL  = 2'b01,
    ST_EXTRA = 2'b10
  } state_t;
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;
`endif

  localparam int unsigned I_BIT     = 25;
  localparam int unsigned RS_BIT    = 4;
  localparam int unsigned TYPE_LSB  = 5;
  localparam int unsigned TYPE_MSB  = 6;
  localparam int unsigned IMM5_LSB  = 7;
  localparam int unsigned IMM5_MSB  = 11;
  localparam int unsigned ROT_LSB   = 8;
  localparam int unsigned ROT_MSB   = 11;
  localparam int unsigned IMM8_LSB  = 0;
  localparam int unsigned IMM8_MSB  = 7;

  // True when operand 2 is a register shifted by a register amount.
  function automatic logic is_reg_shift(input logic [31:0] op);
    return !op[I_BIT] && op[RS_BIT];
  endfunction

endpackage

// File: rtl/sft_core.sv
// sft_core: combinational ARM operand-2 shifter (all modes, special encodings).
module sft_core
  import sft_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [31:0]      opcode,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  localparam int unsigned SW    = $clog2(WIDTH);
  localparam logic [7:0]  W_AMT = 8'(WIDTH);

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                            input logic [SW-1:0]    s);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} >> s;
    return dbl[WIDTH-1:0];
  endfunction

  shift_t           sh_type;
  logic [4:0]       imm5;
  logic [7:0]       amt;
  logic [SW-1:0]    amt_lo;
  logic [SW-1:0]    lsl_idx;
  logic [SW-1:0]    lsr_idx;
  logic [5:0]       rot6;
  logic [SW-1:0]    rot;
  logic [WIDTH-1:0] imm8;
  logic [WIDTH-1:0] rot_val;
  logic [WIDTH-1:0] ror_val;
  logic             unused_ok;

  assign unused_ok = ^{inb[WIDTH-1:8], opcode[31:26], opcode[24:12]};

  // Decode operand-2 fields and apply the shift with ARM special cases.
  always_comb begin
    res     = ina;
    cout    = cin;
    sh_type = shift_t'(opcode[TYPE_MSB:TYPE_LSB]);
    imm5    = opcode[IMM5_MSB:IMM5_LSB];
    amt     = opcode[RS_BIT] ? inb[7:0] : {3'b000, imm5};
    amt_lo  = amt[SW-1:0];
    lsl_idx = '0 - amt_lo;
    lsr_idx = amt_lo - SW'(1);
    rot6    = {1'b0, opcode[ROT_MSB:ROT_LSB], 1'b0};
    rot     = rot6[SW-1:0];
    imm8    = WIDTH'(opcode[IMM8_MSB:IMM8_LSB]);
    rot_val = rotr(imm8, rot);
    ror_val = rotr(ina, amt_lo);

    if (opcode[I_BIT]) begin
      res  = rot_val;
      cout = (rot == '0) ? cin : rot_val[WIDTH-1];
    end else if (!opcode[RS_BIT] && (imm5 == '0)) begin
      unique case (sh_type)
        SH_LSL: begin
          res  = ina;
          cout = cin;
        end
        SH_LSR: begin
          res  = '0;
          cout = ina[WIDTH-1];
        end
        SH_ASR: begin
          res  = {WIDTH{ina[WIDTH-1]}};
          cout = ina[WIDTH-1];
        end
        SH_ROR: begin
          res  = {cin, ina[WIDTH-1:1]};
          cout = ina[0];
        end
      endcase
    end else if (amt != '0) begin
      unique case (sh_type)
        SH_LSL: begin
          if (amt < W_AMT) begin
            res  = ina << amt_lo;
            cout = ina[lsl_idx];
          end else begin
            res  = '0;
            cout = (amt == W_AMT) ? ina[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (amt < W_AMT) begin
            res  = ina >> amt_lo;
            cout = ina[lsr_idx];
          end else begin
            res  = '0;
            cout = (amt == W_AMT) ? ina[WIDTH-1] : 1'b0;
          end
        end
        SH_ASR: begin
          if (amt < W_AMT) begin
            res  = $signed(ina) >>> amt_lo;
            cout = ina[lsr_idx];
          end else begin
            res  = {WIDTH{ina[WIDTH-1]}};
            cout = ina[WIDTH-1];
          end
        end
        SH_ROR: begin
          if (amt_lo == '0) begin
            res  = ina;
            cout = ina[WIDTH-1];
          end else begin
            res  = ror_val;
            cout = ror_val[WIDTH-1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sft_pipe_unit.sv
// sft_pipe_unit: registered, valid/ready wrapper around sft_core.
// Optional build macro: SFT_REGSHIFT_2CYC_EN makes register-amount shifts take
// two cycles through an EXTRA state; without it every mode has latency 1.
module sft_pipe_unit
  import sft_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] INA,
  input  logic [WIDTH-1:0] INB,
  input  logic [31:0]      OPCODE,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             COUT
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             accept;

  logic [WIDTH-1:0] core_ina, core_inb, core_res;
  logic [31:0]      core_op;
  logic             core_cin, core_cout;

`ifdef SFT_REGSHIFT_2CYC_EN
  logic [WIDTH-1:0] ina_q, ina_d;
  logic [WIDTH-1:0] inb_q, inb_d;
  logic [31:0]      op_q, op_d;
  logic             cin_q, cin_d;
`endif

  assign OUT_VALID = (state_q == ST_FULL);
  assign OUT       = out_q;
  assign COUT      = cout_q;

  // Core sees live inputs, or the captured request while finishing a register shift.
  always_comb begin
    core_ina = INA;
    core_inb = INB;
    core_op  = OPCODE;
    core_cin = CIN;
`ifdef SFT_REGSHIFT_2CYC_EN
    if (state_q == ST_EXTRA) begin
      core_ina = ina_q;
      core_inb = inb_q;
      core_op  = op_q;
      core_cin = cin_q;
    end
`endif
  end

  sft_core #(.WIDTH(WIDTH)) u_core (
    .ina    (core_ina),
    .inb    (core_inb),
    .opcode (core_op),
    .cin    (core_cin),
    .res    (core_res),
    .cout   (core_cout)
  );

  // Handshake, next state and result-register updates.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    cout_d   = cout_q;
`ifdef SFT_REGSHIFT_2CYC_EN
    ina_d    = ina_q;
    inb_d    = inb_q;
    op_d     = op_q;
    cin_d    = cin_q;
    IN_READY = (state_q != ST_EXTRA) && (!OUT_VALID || OUT_READY);
`else
    IN_READY = !OUT_VALID || OUT_READY;
`endif
    accept   = IN_VALID && IN_READY;

    unique case (state_q)
      ST_IDLE, ST_FULL: begin
        if (accept) begin
`ifdef SFT_REGSHIFT_2CYC_EN
          if (is_reg_shift(OPCODE)) begin
            state_d = ST_EXTRA;
            ina_d   = INA;
            inb_d   = INB;
            op_d    = OPCODE;
            cin_d   = CIN;
          end else begin
            state_d = ST_FULL;
            out_d   = core_res;
            cout_d  = core_cout;
          end
`else
          state_d = ST_FULL;
          out_d   = core_res;
          cout_d  = core_cout;
`endif
        end else if (OUT_VALID && OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
`ifdef SFT_REGSHIFT_2CYC_EN
      ST_EXTRA: begin
        state_d = ST_FULL;
        out_d   = core_res;
        cout_d  = core_cout;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset discards any held or in-flight result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SFT_REGSHIFT_2CYC_EN
      ina_q   <= '0;
      inb_q   <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
`ifdef SFT_REGSHIFT_2CYC_EN
      ina_q   <= ina_d;
      inb_q   <= inb_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
`endif
    end
  end

endmodule

// File: tb/tb_sft_pipe_unit.sv
// tb_sft_pipe_unit: directed vectors with literal expectations plus a
// cycle-by-cycle scoreboard driven by an arithmetic reference model.
module tb_sft_pipe_unit;

`ifdef SFT_REGSHIFT_2CYC_EN
  localparam int RL = 2;
`else
  localparam int RL = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] INA = '0;
  logic [31:0] INB = '0;
  logic [31:0] OPCODE = '0;
  logic        CIN = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] OUT;
  logic        COUT;

  int vectors = 0;
  int miscompares = 0;

  sft_pipe_unit #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .INA       (INA),
    .INB       (INB),
    .OPCODE    (OPCODE),
    .CIN       (CIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT       (OUT),
    .COUT      (COUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int r);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[i] = x[(i + r) % 32];
    return y;
  endfunction

  // Reference: returns {cout, out}.
  function automatic logic [32:0] model(input logic [31:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    logic [31:0] o;
    logic [63:0] w;
    logic [1:0]  t;
    int n;
    int r;
    t = op[6:5];
    if (op[25]) begin
      r = (2 * int'(op[11:8])) % 32;
      o = ror32({24'd0, op[7:0]}, r);
      return {(r == 0) ? c : o[31], o};
    end
    n = op[4] ? int'(b[7:0]) : int'(op[11:7]);
    if (n == 0) begin
      if (op[4] || t == 2'd0) return {c, a};
      if (t == 2'd3) return {a[0], c, a[31:1]};
      n = 32;
    end
    case (t)
      2'd0: begin
        w = {32'd0, a} << n;
        return {w[32], w[31:0]};
      end
      2'd1: begin
        w = {a, 32'd0} >> n;
        return {w[31], w[63:32]};
      end
      2'd2: begin
        w = $unsigned($signed({a, 32'd0}) >>> ((n > 63) ? 63 : n));
        return {w[31], w[63:32]};
      end
      default: begin
        r = n % 32;
        if (r == 0) return {a[31], a};
        o = ror32(a, r);
        return {o[31], o};
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [31:0] op);
    return (!op[25] && op[4]) ? RL : 1;
  endfunction

  typedef struct {
    logic [31:0] o;
    logic        c;
    int          vis;
  } exp_t;

  exp_t q[$];

  // Scoreboard: check handshake and data every cycle against the model.
  initial begin
    int          cyc;
    logic [31:0] last_o;
    logic        last_c;
    logic        ev, ex, er;
    logic [32:0] m;
    exp_t        ent;
    cyc = 0;
    last_o = '0;
    last_c = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        q.delete();
        last_o = '0;
        last_c = 1'b0;
        continue;
      end
      ev = (q.size() > 0) && (q[0].vis <= cyc);
      ex = (q.size() > 0) && (q[0].vis > cyc);
      er = !ex && (!ev || OUT_READY);
      chk("sb_out_valid", {63'd0, OUT_VALID}, {63'd0, ev});
      chk("sb_in_ready", {63'd0, IN_READY}, {63'd0, er});
      if (ev) begin
        chk("sb_out", {32'd0, OUT}, {32'd0, q[0].o});
        chk("sb_cout", {63'd0, COUT}, {63'd0, q[0].c});
      end else begin
        chk("sb_out_hold", {31'd0, COUT, OUT}, {31'd0, last_c, last_o});
      end
      if (ev && OUT_READY) begin
        last_o = q[0].o;
        last_c = q[0].c;
        void'(q.pop_front());
      end
      if (IN_VALID && er) begin
        m = model(OPCODE, INA, INB, CIN);
        ent.o = m[31:0];
        ent.c = m[32];
        ent.vis = cyc + lat_of(OPCODE);
        q.push_back(ent);
      end
    end
  end

  // One request, then wait for its result and compare to literal values.
  task automatic run_vec(input string nm, input logic [31:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic c, input logic [31:0] eo,
                         input logic ec, input int elat);
    int lat;
    logic ok;
    OPCODE = op; INA = a; INB = b; CIN = c;
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge CLK);
      ok = IN_READY;
    end
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    if (!ok) begin
      chk({nm, "_accept"}, 64'd0, 64'd1);
      return;
    end
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge CLK);
      lat++;
      ok = OUT_VALID;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    chk({nm, "_out"}, {32'd0, OUT}, {32'd0, eo});
    chk({nm, "_cout"}, {63'd0, COUT}, {63'd0, ec});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    #3;
    chk("rst_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("rst_out", {32'd0, OUT}, 64'd0);
    chk("rst_cout", {63'd0, COUT}, 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    run_vec("imm50",    32'he3a00050, 32'h50,         32'h10,         1'b0, 32'h00000050, 1'b0, 1);
    run_vec("immff_r8", 32'he3a004ff, 32'h0,          32'h0,          1'b0, 32'hFF000000, 1'b1, 1);
    run_vec("imm_rot0", 32'he3a000ab, 32'h0,          32'h0,          1'b1, 32'h000000AB, 1'b1, 1);
    run_vec("rrx",      32'he1a00060, 32'h00000003,   32'h0,          1'b1, 32'h80000001, 1'b1, 1);
    run_vec("asr0",     32'he1a00040, 32'h80000000,   32'h0,          1'b0, 32'hFFFFFFFF, 1'b1, 1);
    run_vec("lsr_i4",   32'he1a00220, 32'h000000F8,   32'h0,          1'b0, 32'h0000000F, 1'b1, 1);
    run_vec("lsl_i1",   32'he1a00080, 32'h80000001,   32'h0,          1'b0, 32'h00000002, 1'b1, 1);
    run_vec("lsl_r32",  32'he1a00110, 32'h1,          32'd32,         1'b0, 32'h0,        1'b1, RL);
    run_vec("lsl_r33",  32'he1a00110, 32'h1,          32'd33,         1'b0, 32'h0,        1'b0, RL);
    run_vec("lsl_r0",   32'he1a00110, 32'h1,          32'd0,          1'b1, 32'h1,        1'b1, RL);
    run_vec("lsr_r32",  32'he1a00130, 32'h80000000,   32'd32,         1'b0, 32'h0,        1'b1, RL);
    run_vec("asr_r200", 32'he1a00150, 32'h70000001,   32'h123456C8,   1'b1, 32'h0,        1'b0, RL);
    run_vec("ror_r64",  32'he1a00170, 32'h80000001,   32'd64,         1'b0, 32'h80000001, 1'b1, RL);
    run_vec("ror_r36",  32'he1a00170, 32'h0000000F,   32'd36,         1'b0, 32'hF0000000, 1'b1, RL);

    // Back-pressure: hold a result while a new request waits.
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    OPCODE = 32'he3a004ff; INA = '0; INB = '0; CIN = 1'b0;
    @(posedge CLK);
    #1 OPCODE = 32'he1a00080; INA = 32'h80000001;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      held = OUT;
      chk("bp_out", {32'd0, held}, 64'hFF000000);
      chk("bp_valid", {63'd0, OUT_VALID}, 64'd1);
      chk("bp_in_ready", {63'd0, IN_READY}, 64'd0);
    end
    @(posedge CLK);
    #1 OUT_READY = 1'b1;
    @(negedge CLK);
    chk("pa_in_ready", {63'd0, IN_READY}, 64'd1);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    @(negedge CLK);
    chk("pa_valid", {63'd0, OUT_VALID}, 64'd1);
    chk("pa_out", {32'd0, OUT}, 64'h00000002);
    chk("pa_cout", {63'd0, COUT}, 64'd1);

    // Reset while a result is held.
    @(posedge CLK);
    #1 OUT_READY = 1'b0; IN_VALID = 1'b1; OPCODE = 32'he3a000ab; CIN = 1'b0;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    @(negedge CLK);
    chk("hold_out", {32'd0, OUT}, 64'h000000AB);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("arst_out", {32'd0, OUT}, 64'd0);
    chk("arst_cout", {63'd0, COUT}, 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0; OUT_READY = 1'b1;

    // Mixed traffic with random stalls, checked by the scoreboard.
    for (int i = 0; i < 300; i++) begin
      OPCODE    = $urandom;
      INA       = $urandom;
      INB       = {$urandom_range(0, 255) > 200 ? 24'hFFFFFF : 24'd0, 8'($urandom_range(0, 70))};
      CIN       = 1'($urandom_range(0, 1));
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
